// File: rtl/ptw_mem_arbiter.sv
// Shares one AXI read port between the iTLB and dTLB page-table walkers: round-robin grant,
// one transaction outstanding, response routed to the grantee, WAIT watchdog and flush discard.
module ptw_mem_arbiter #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  TLB_FLUSH,
  input  logic                  I_ADDR_VALID,
  input  logic [ADDR_WIDTH-1:0] I_ADDR,
  output logic                  I_DATA_VALID,
  output logic [DATA_WIDTH-1:0] I_DATA,
  input  logic                  D_ADDR_VALID,
  input  logic [ADDR_WIDTH-1:0] D_ADDR,
  output logic                  D_DATA_VALID,
  output logic [DATA_WIDTH-1:0] D_DATA,
  output logic                  M_ADDR_VALID,
  output logic [ADDR_WIDTH-1:0] M_ADDR,
  input  logic                  M_ADDR_READY,
  input  logic                  M_DATA_VALID,
  input  logic [DATA_WIDTH-1:0] M_DATA,
  output logic                  TIMEOUT_ERR
);

  localparam bit WDOG_EN = (TIMEOUT_CYCLES > 0);
  localparam int CNT_W   = WDOG_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_e;
  typedef enum logic       {GNT_I, GNT_D}          grant_e;

  state_e                state_q, state_d;
  grant_e                grant_q, grant_d, last_q, last_d, pick;
  logic                  pend_i_q, pend_i_d, pend_d_q, pend_d_d;
  logic [ADDR_WIDTH-1:0] addr_i_q, addr_i_d, addr_d_q, addr_d_d;
  logic                  discard_q, discard_d;
  logic [CNT_W-1:0]      wdog_q, wdog_d, wdog_inc;
  logic                  resp_fire;
  logic [DATA_WIDTH-1:0] resp_data;
  logic                  m_addr_valid_d, i_data_valid_d, d_data_valid_d, timeout_err_d;
  logic [ADDR_WIDTH-1:0] m_addr_d;
  logic [DATA_WIDTH-1:0] i_data_d, d_data_d;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_d        = state_q;
    grant_d        = grant_q;
    last_d         = last_q;
    pick           = GNT_I;
    pend_i_d       = pend_i_q;
    pend_d_d       = pend_d_q;
    addr_i_d       = addr_i_q;
    addr_d_d       = addr_d_q;
    discard_d      = discard_q;
    wdog_d         = wdog_q;
    wdog_inc       = (wdog_q == CNT_LIMIT) ? wdog_q : wdog_q + CNT_W'(1);
    resp_fire      = 1'b0;
    resp_data      = '0;
    m_addr_valid_d = M_ADDR_VALID;
    m_addr_d       = M_ADDR;
    i_data_valid_d = 1'b0;
    d_data_valid_d = 1'b0;
    timeout_err_d  = 1'b0;
    i_data_d       = I_DATA;
    d_data_d       = D_DATA;

    // Flush beats a same-cycle request pulse; otherwise the latest pulse overwrites.
    if (TLB_FLUSH) begin
      pend_i_d = 1'b0;
      pend_d_d = 1'b0;
    end else begin
      if (I_ADDR_VALID) begin
        pend_i_d = 1'b1;
        addr_i_d = I_ADDR;
      end
      if (D_ADDR_VALID) begin
        pend_d_d = 1'b1;
        addr_d_d = D_ADDR;
      end
    end

    unique case (state_q)
      S_IDLE: begin
        if (pend_i_d || pend_d_d) begin
          if (pend_i_d && pend_d_d) pick = (last_q == GNT_I) ? GNT_D : GNT_I;
          else                      pick = pend_i_d ? GNT_I : GNT_D;
          m_addr_valid_d = 1'b1;
          m_addr_d       = (pick == GNT_I) ? addr_i_d : addr_d_d;
          grant_d        = pick;
          last_d         = pick;
          state_d        = S_REQ;
        end
      end
      S_REQ: begin
        if (TLB_FLUSH) discard_d = 1'b1;
        if (M_ADDR_READY) begin
          m_addr_valid_d = 1'b0;
          wdog_d         = '0;
          state_d        = S_WAIT;
          // A grantee pulse on its own accept edge is a fresh request and stays pending.
          if (grant_q == GNT_I && !I_ADDR_VALID) pend_i_d = 1'b0;
          if (grant_q == GNT_D && !D_ADDR_VALID) pend_d_d = 1'b0;
        end
      end
      S_WAIT: begin
        if (TLB_FLUSH) discard_d = 1'b1;
        if (M_DATA_VALID) begin
          resp_fire = 1'b1;
          resp_data = M_DATA;
        end else if (WDOG_EN) begin
          wdog_d = wdog_inc;
          if (wdog_inc == CNT_LIMIT) begin
            resp_fire     = 1'b1;
            timeout_err_d = 1'b1;
          end
        end
        if (resp_fire) begin
          state_d   = S_IDLE;
          discard_d = 1'b0;
          if (!(discard_q || TLB_FLUSH)) begin
            if (grant_q == GNT_I) begin
              i_data_valid_d = 1'b1;
              i_data_d       = resp_data;
            end else begin
              d_data_valid_d = 1'b1;
              d_data_d       = resp_data;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q      <= S_IDLE;
      grant_q      <= GNT_I;
      last_q       <= GNT_D;
      pend_i_q     <= 1'b0;
      pend_d_q     <= 1'b0;
      addr_i_q     <= '0;
      addr_d_q     <= '0;
      discard_q    <= 1'b0;
      wdog_q       <= '0;
      M_ADDR_VALID <= 1'b0;
      M_ADDR       <= '0;
      I_DATA_VALID <= 1'b0;
      I_DATA       <= '0;
      D_DATA_VALID <= 1'b0;
      D_DATA       <= '0;
      TIMEOUT_ERR  <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_q       <= last_d;
      pend_i_q     <= pend_i_d;
      pend_d_q     <= pend_d_d;
      addr_i_q     <= addr_i_d;
      addr_d_q     <= addr_d_d;
      discard_q    <= discard_d;
      wdog_q       <= wdog_d;
      M_ADDR_VALID <= m_addr_valid_d;
      M_ADDR       <= m_addr_d;
      I_DATA_VALID <= i_data_valid_d;
      I_DATA       <= i_data_d;
      D_DATA_VALID <= d_data_valid_d;
      D_DATA       <= d_data_d;
      TIMEOUT_ERR  <= timeout_err_d;
    end
  end

endmodule

// File: tb/tb_ptw_mem_arbiter.sv
// Self-checking bench for ptw_mem_arbiter: vector table, hand-written corner sequences and
// randomized rounds checked against a transaction-level round-robin model.
module tb_ptw_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;

  logic          CLK = 1'b0;
  logic          RST_N, TLB_FLUSH;
  logic          I_ADDR_VALID, D_ADDR_VALID, I_DATA_VALID, D_DATA_VALID;
  logic [AW-1:0] I_ADDR, D_ADDR, M_ADDR;
  logic [DW-1:0] I_DATA, D_DATA, M_DATA;
  logic          M_ADDR_VALID, M_ADDR_READY, M_DATA_VALID, TIMEOUT_ERR;

  int n_checks = 0;
  int n_errors = 0;

  always #5 CLK = ~CLK;

  ptw_mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
    .CLK(CLK), .RST_N(RST_N), .TLB_FLUSH(TLB_FLUSH),
    .I_ADDR_VALID(I_ADDR_VALID), .I_ADDR(I_ADDR), .I_DATA_VALID(I_DATA_VALID), .I_DATA(I_DATA),
    .D_ADDR_VALID(D_ADDR_VALID), .D_ADDR(D_ADDR), .D_DATA_VALID(D_DATA_VALID), .D_DATA(D_DATA),
    .M_ADDR_VALID(M_ADDR_VALID), .M_ADDR(M_ADDR), .M_ADDR_READY(M_ADDR_READY),
    .M_DATA_VALID(M_DATA_VALID), .M_DATA(M_DATA), .TIMEOUT_ERR(TIMEOUT_ERR)
  );

  typedef struct {
    logic        pi;
    logic [31:0] ai;
    logic        pd;
    logic [31:0] ad;
    int          rdy;
    int          dat;
    logic [31:0] rdata;
    logic [31:0] exp_addr;
    logic        exp_d;
  } vec_t;

  vec_t vecs[6];

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic do_reset();
    RST_N = 1'b0;  TLB_FLUSH = 1'b0;
    I_ADDR_VALID = 1'b0; I_ADDR = '0; D_ADDR_VALID = 1'b0; D_ADDR = '0;
    M_ADDR_READY = 1'b0; M_DATA_VALID = 1'b0; M_DATA = '0;
    repeat (2) cyc();
    RST_N = 1'b1;
    cyc();
  endtask

  task automatic pulse(input logic pi, input logic [31:0] ai, input logic pd, input logic [31:0] ad);
    I_ADDR_VALID = pi; I_ADDR = ai; D_ADDR_VALID = pd; D_ADDR = ad;
    cyc();
    I_ADDR_VALID = 1'b0; D_ADDR_VALID = 1'b0;
  endtask

  task automatic wait_issue(input string tag);
    int n = 0;
    while (!M_ADDR_VALID && n < 32) begin
      cyc();
      n++;
    end
    check_bit({tag, "_issued"}, M_ADDR_VALID, 1'b1);
  endtask

  // Memory side: hold off ready for rdy cycles, then return rdata after dat idle WAIT cycles.
  task automatic serve(input int rdy, input int dat, input logic [31:0] rdata, input logic [31:0] exp_addr);
    for (int i = 0; i < rdy; i++) begin
      check_bit("req_hold_valid", M_ADDR_VALID, 1'b1);
      check("req_hold_addr", M_ADDR, exp_addr);
      cyc();
    end
    M_ADDR_READY = 1'b1;
    cyc();
    M_ADDR_READY = 1'b0;
    check_bit("accept_drops_valid", M_ADDR_VALID, 1'b0);
    for (int i = 0; i < dat; i++) cyc();
    M_DATA_VALID = 1'b1; M_DATA = rdata;
    cyc();
    M_DATA_VALID = 1'b0;
  endtask

  task automatic check_resp(input string tag, input logic to_d, input logic [31:0] data);
    check_bit({tag, "_i_valid"}, I_DATA_VALID, !to_d);
    check_bit({tag, "_d_valid"}, D_DATA_VALID, to_d);
    check({tag, "_data"}, to_d ? D_DATA : I_DATA, data);
  endtask

  // Transaction-level model: pending flag + latest address per walker, round-robin pointer.
  task automatic random_phase(input int rounds);
    logic        mp[2];
    logic [31:0] ma[2];
    int          last, w, o, mask;
    logic [31:0] rdata, na;
    last = 1;
    mp[0] = 1'b0; mp[1] = 1'b0;
    for (int r = 0; r < rounds; r++) begin
      mask  = $urandom_range(1, 3);
      ma[0] = $urandom;
      ma[1] = $urandom;
      mp[0] = mask[0];
      mp[1] = mask[1];
      pulse(mask[0], ma[0], mask[1], ma[1]);
      while (mp[0] || mp[1]) begin
        w = (mp[0] && mp[1]) ? 1 - last : (mp[0] ? 0 : 1);
        wait_issue("rnd");
        check("rnd_addr", M_ADDR, ma[w]);
        o = 1 - w;
        if ($urandom_range(0, 2) == 0) begin
          na = $urandom;
          if (o == 0) pulse(1'b1, na, 1'b0, 32'h0);
          else        pulse(1'b0, 32'h0, 1'b1, na);
          mp[o] = 1'b1;
          ma[o] = na;
        end
        rdata = $urandom;
        serve($urandom_range(0, 3), $urandom_range(0, 4), rdata, ma[w]);
        check_resp("rnd", w == 1, rdata);
        check_bit("rnd_no_issue_on_delivery", M_ADDR_VALID, 1'b0);
        mp[w] = 1'b0;
        last  = w;
        cyc();
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: bench did not reach its summary");
    $fatal(1, "bench time limit expired");
  end

  initial begin
    vecs[0] = '{1'b1, 32'h0000_1000, 1'b1, 32'h0000_2000, 0, 1, 32'h1111_0001, 32'h0000_1000, 1'b0};
    vecs[1] = '{1'b0, 32'h0,         1'b0, 32'h0,         1, 0, 32'h2222_0002, 32'h0000_2000, 1'b1};
    vecs[2] = '{1'b1, 32'h003E_8004, 1'b0, 32'h0,         0, 2, 32'h0004_00CF, 32'h003E_8004, 1'b0};
    vecs[3] = '{1'b1, 32'h0000_1100, 1'b1, 32'h0000_2100, 2, 0, 32'h3333_0003, 32'h0000_2100, 1'b1};
    vecs[4] = '{1'b0, 32'h0,         1'b0, 32'h0,         0, 3, 32'h4444_0004, 32'h0000_1100, 1'b0};
    vecs[5] = '{1'b0, 32'h0,         1'b1, 32'h0ABC_0008, 5, 1, 32'h0000_D0D1, 32'h0ABC_0008, 1'b1};

    do_reset();
    check_bit("rst_m_valid", M_ADDR_VALID, 1'b0);
    check("rst_m_addr", M_ADDR, 32'h0);
    check_bit("rst_i_valid", I_DATA_VALID, 1'b0);
    check("rst_i_data", I_DATA, 32'h0);
    check_bit("rst_d_valid", D_DATA_VALID, 1'b0);
    check("rst_d_data", D_DATA, 32'h0);
    check_bit("rst_timeout", TIMEOUT_ERR, 1'b0);

    // Collisions, single request and back-pressure; every issue appears one cycle after its trigger.
    foreach (vecs[k]) begin
      if (vecs[k].pi || vecs[k].pd) pulse(vecs[k].pi, vecs[k].ai, vecs[k].pd, vecs[k].ad);
      check_bit($sformatf("vec%0d_issue", k), M_ADDR_VALID, 1'b1);
      check($sformatf("vec%0d_addr", k), M_ADDR, vecs[k].exp_addr);
      serve(vecs[k].rdy, vecs[k].dat, vecs[k].rdata, vecs[k].exp_addr);
      check_resp($sformatf("vec%0d", k), vecs[k].exp_d, vecs[k].rdata);
      cyc();
      check_bit($sformatf("vec%0d_one_cycle", k), I_DATA_VALID | D_DATA_VALID, 1'b0);
    end

    // Stray data in REQ is ignored; grantee pulse on its accept edge stays pending.
    pulse(1'b1, 32'h0000_7000, 1'b0, 32'h0);
    check("repulse_addr", M_ADDR, 32'h0000_7000);
    M_DATA_VALID = 1'b1; M_DATA = 32'hDEAD_0000;
    cyc();
    M_DATA_VALID = 1'b0;
    check_bit("stray_req_no_valid", I_DATA_VALID, 1'b0);
    check_bit("stray_req_still_valid", M_ADDR_VALID, 1'b1);
    M_ADDR_READY = 1'b1; I_ADDR_VALID = 1'b1; I_ADDR = 32'h0000_7100;
    cyc();
    M_ADDR_READY = 1'b0; I_ADDR_VALID = 1'b0;
    M_DATA_VALID = 1'b1; M_DATA = 32'h0000_0077;
    cyc();
    M_DATA_VALID = 1'b0;
    check_resp("repulse_first", 1'b0, 32'h0000_0077);
    cyc();
    check_bit("repulse_reissue", M_ADDR_VALID, 1'b1);
    check("repulse_reissue_addr", M_ADDR, 32'h0000_7100);
    serve(0, 0, 32'h0000_0078, 32'h0000_7100);
    check_resp("repulse_second", 1'b0, 32'h0000_0078);
    cyc();

    // Watchdog: D times out after exactly 8 WAIT cycles, pending I goes next.
    pulse(1'b0, 32'h0, 1'b1, 32'h0000_D000);
    check("to_d_addr", M_ADDR, 32'h0000_D000);
    pulse(1'b1, 32'h0000_E000, 1'b0, 32'h0);
    M_ADDR_READY = 1'b1;
    cyc();
    M_ADDR_READY = 1'b0;
    for (int i = 0; i < TO; i++) begin
      check_bit($sformatf("to_wait%0d_d_valid", i), D_DATA_VALID, 1'b0);
      cyc();
    end
    check_bit("to_d_valid", D_DATA_VALID, 1'b1);
    check("to_d_data", D_DATA, 32'h0);
    check_bit("to_err", TIMEOUT_ERR, 1'b1);
    check_bit("to_i_valid", I_DATA_VALID, 1'b0);
    check_bit("to_no_issue_on_delivery", M_ADDR_VALID, 1'b0);
    cyc();
    check_bit("to_err_one_cycle", TIMEOUT_ERR, 1'b0);
    check_bit("to_next_issue", M_ADDR_VALID, 1'b1);
    check("to_next_addr", M_ADDR, 32'h0000_E000);
    serve(0, 0, 32'h0E0E_0E0E, 32'h0000_E000);
    check_resp("to_next", 1'b0, 32'h0E0E_0E0E);
    cyc();

    // Flush with a same-cycle pulse drops the pulse.
    TLB_FLUSH = 1'b1;
    pulse(1'b1, 32'h0000_8000, 1'b0, 32'h0);
    TLB_FLUSH = 1'b0;
    check_bit("flush_pulse_dropped", M_ADDR_VALID, 1'b0);
    cyc();
    check_bit("flush_pulse_dropped_2", M_ADDR_VALID, 1'b0);

    // Flush in REQ: handshake completes, response discarded.
    pulse(1'b0, 32'h0, 1'b1, 32'h0000_F000);
    TLB_FLUSH = 1'b1;
    cyc();
    TLB_FLUSH = 1'b0;
    check_bit("flush_req_held", M_ADDR_VALID, 1'b1);
    check("flush_req_addr", M_ADDR, 32'h0000_F000);
    M_ADDR_READY = 1'b1;
    cyc();
    M_ADDR_READY = 1'b0;
    M_DATA_VALID = 1'b1; M_DATA = 32'h0000_0BAD;
    cyc();
    M_DATA_VALID = 1'b0;
    check_bit("flush_req_no_d_valid", D_DATA_VALID, 1'b0);
    check_bit("flush_req_no_i_valid", I_DATA_VALID, 1'b0);
    cyc();
    check_bit("flush_req_idle", M_ADDR_VALID, 1'b0);

    // Flush in WAIT: response discarded, next request served normally.
    pulse(1'b1, 32'h0000_5000, 1'b0, 32'h0);
    check("flush_wait_addr", M_ADDR, 32'h0000_5000);
    M_ADDR_READY = 1'b1;
    cyc();
    M_ADDR_READY = 1'b0;
    TLB_FLUSH = 1'b1;
    cyc();
    TLB_FLUSH = 1'b0;
    cyc();
    M_DATA_VALID = 1'b1; M_DATA = 32'h0000_5555;
    cyc();
    M_DATA_VALID = 1'b0;
    check_bit("flush_wait_no_i_valid", I_DATA_VALID, 1'b0);
    check_bit("flush_wait_no_d_valid", D_DATA_VALID, 1'b0);
    cyc();
    check_bit("flush_wait_idle", M_ADDR_VALID, 1'b0);
    pulse(1'b0, 32'h0, 1'b1, 32'h0000_6000);
    check_bit("after_flush_issue", M_ADDR_VALID, 1'b1);
    check("after_flush_addr", M_ADDR, 32'h0000_6000);
    serve(0, 0, 32'h6666_0006, 32'h0000_6000);
    check_resp("after_flush", 1'b1, 32'h6666_0006);
    cyc();

    do_reset();
    random_phase(40);

    // Reset during WAIT, stray response afterwards.
    pulse(1'b1, 32'h0000_9000, 1'b0, 32'h0);
    check("rstw_addr", M_ADDR, 32'h0000_9000);
    M_ADDR_READY = 1'b1;
    cyc();
    M_ADDR_READY = 1'b0;
    RST_N = 1'b0;
    #1;
    check_bit("rstw_m_valid", M_ADDR_VALID, 1'b0);
    check("rstw_m_addr", M_ADDR, 32'h0);
    check("rstw_i_data", I_DATA, 32'h0);
    check("rstw_d_data", D_DATA, 32'h0);
    cyc();
    RST_N = 1'b1;
    cyc();
    M_DATA_VALID = 1'b1; M_DATA = 32'h0000_9999;
    cyc();
    M_DATA_VALID = 1'b0;
    check_bit("rstw_no_i_valid", I_DATA_VALID, 1'b0);
    check_bit("rstw_no_d_valid", D_DATA_VALID, 1'b0);
    check_bit("rstw_idle", M_ADDR_VALID, 1'b0);
    check("rstw_i_data_kept", I_DATA, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
